// File: rtl/a_frame_packer.sv
// a_frame_packer
// Packs a serial stream of BUM-bit words (valid/ready) into a VUM-lane frame of
// AUM words per lane and hands the frame downstream over its own valid/ready.
// A frame closes on in_last or when full; short frames are zero padded.
//
// Ports:
//   clk, rst_n         clock (rising edge) and synchronous active-low reset
//   in_valid/in_ready  input word handshake; in_data word, in_last closes frame
//   out_valid/out_ready frame handshake
//   my_data_abv        frame storage, lane v, word a (word 0 in the LSBs)
//   my_data_ab         XOR of all lanes (parity lane)
//   my_data_av         per-word written mask (1 = real word, 0 = pad)
//   my_data_z          frame was terminated early (padded)
//   out_words          number of real words in the frame
module a_frame_packer #(
  parameter int AUM = 80,
  parameter int BUM = 70,
  parameter int VUM = 1,
  localparam int CW = $clog2(AUM * VUM + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUM-1:0]           in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AUM-1:0][BUM-1:0]  my_data_abv [VUM],
  output logic [AUM-1:0][BUM-1:0]  my_data_ab,
  output logic [AUM-1:0]           my_data_av [VUM],
  output logic                     my_data_z,
  output logic [CW-1:0]            out_words
);

  if (AUM < 1 || BUM < 1 || VUM < 1) begin : g_bad_params
    $error("a_frame_packer: AUM, BUM and VUM must all be >= 1");
  end

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam int NWORDS = AUM * VUM;

  state_e                    state_q;
  logic [CW-1:0]             k_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [AUM-1:0][BUM-1:0]   abv_q [VUM];
  logic [AUM-1:0][BUM-1:0]   abv_d [VUM];
  logic [AUM-1:0]            av_q  [VUM];
  logic [AUM-1:0]            av_d  [VUM];
  logic [AUM-1:0][BUM-1:0]   ab_q;
  logic [AUM-1:0][BUM-1:0]   ab_d;
  logic                      z_q;
  logic [CW-1:0]             words_q;
  logic [CW-1:0]             k_inc_s;
  logic                      accept_s;
  logic                      close_s;

  // in_ready is only ever high in FILL, so it alone qualifies an accept.
  assign accept_s = in_valid & in_ready_q;
  assign k_inc_s  = k_q + CW'(1);
  assign close_s  = accept_s & (in_last | (k_q == CW'(NWORDS - 1)));

  // Next frame storage: write the accepted word; the first word of a frame
  // clears every other position so nothing leaks from the previous frame.
  always_comb begin
    ab_d = '0;
    for (int v = 0; v < VUM; v++) begin
      for (int a = 0; a < AUM; a++) begin
        if (accept_s && (k_q == CW'(v * AUM + a))) begin
          abv_d[v][a] = in_data;
          av_d[v][a]  = 1'b1;
        end else if (accept_s && (k_q == '0)) begin
          abv_d[v][a] = '0;
          av_d[v][a]  = 1'b0;
        end else begin
          abv_d[v][a] = abv_q[v][a];
          av_d[v][a]  = av_q[v][a];
        end
      end
      ab_d = ab_d ^ abv_d[v];
    end
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ab_q        <= '0;
      z_q         <= 1'b0;
      words_q     <= '0;
      for (int v = 0; v < VUM; v++) begin
        abv_q[v] <= '0;
        av_q[v]  <= '0;
      end
    end else begin
      case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept_s) begin
            k_q <= k_inc_s;
            for (int v = 0; v < VUM; v++) begin
              abv_q[v] <= abv_d[v];
              av_q[v]  <= av_d[v];
            end
            if (close_s) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              words_q     <= k_inc_s;
              z_q         <= (k_inc_s < CW'(NWORDS));
              ab_q        <= ab_d;
            end else begin
              state_q <= S_FILL;
            end
          end else begin
            state_q <= S_FILL;
          end
        end
        S_HOLD: begin
          if (out_valid_q && out_ready) begin
            state_q     <= S_FILL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            k_q         <= '0;
          end else begin
            state_q <= S_HOLD;
          end
        end
        default: begin
          state_q     <= S_FILL;
          k_q         <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign my_data_abv = abv_q;
  assign my_data_av  = av_q;
  assign my_data_ab  = ab_q;
  assign my_data_z   = z_q;
  assign out_words   = words_q;

endmodule

// File: tb/tb_a_frame_packer.sv
module tb_a_frame_packer;
  localparam int AUM = 4;
  localparam int BUM = 8;
  localparam int VUM = 2;
  localparam int CW  = $clog2(AUM * VUM + 1);
  localparam int NW  = AUM * VUM;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [BUM-1:0]          in_data = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [AUM-1:0][BUM-1:0] my_data_abv [VUM];
  logic [AUM-1:0][BUM-1:0] my_data_ab;
  logic [AUM-1:0]          my_data_av [VUM];
  logic                    my_data_z;
  logic [CW-1:0]           out_words;

  a_frame_packer #(.AUM(AUM), .BUM(BUM), .VUM(VUM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .my_data_abv(my_data_abv), .my_data_ab(my_data_ab),
    .my_data_av(my_data_av), .my_data_z(my_data_z), .out_words(out_words)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // Behavioural model: words of the open frame and the expected held frame.
  logic [BUM-1:0]          cur[$];
  bit                      m_hold = 1'b0;
  bit                      m_rdy  = 1'b0;
  bit                      m_ov   = 1'b0;
  bit                      m_acc  = 1'b0;
  logic [AUM-1:0][BUM-1:0] e_abv [VUM];
  logic [AUM-1:0][BUM-1:0] e_ab;
  logic [AUM-1:0]          e_av [VUM];
  logic                    e_z;
  logic [CW-1:0]           e_words;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic build_frame();
    for (int v = 0; v < VUM; v++) begin
      e_abv[v] = '0;
      e_av[v]  = '0;
    end
    foreach (cur[i]) begin
      e_abv[i / AUM][i % AUM] = cur[i];
      e_av[i / AUM][i % AUM]  = 1'b1;
    end
    e_ab = '0;
    for (int v = 0; v < VUM; v++) e_ab = e_ab ^ e_abv[v];
    e_words = CW'(cur.size());
    e_z     = (cur.size() < NW);
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    m_acc = 1'b0;
    if (!rst_n) begin
      m_hold = 1'b0; m_rdy = 1'b0; m_ov = 1'b0;
      cur.delete();
    end else if (!m_hold) begin
      if (in_valid && m_rdy) begin
        m_acc = 1'b1;
        cur.push_back(in_data);
        if (in_last || cur.size() == NW) begin
          build_frame();
          m_hold = 1'b1; m_rdy = 1'b0; m_ov = 1'b1;
        end else m_rdy = 1'b1;
      end else m_rdy = 1'b1;
    end else if (out_ready) begin
      m_hold = 1'b0; m_ov = 1'b0; m_rdy = 1'b1;
      cur.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        for (int v = 0; v < VUM; v++) begin
          check("abv", 64'(my_data_abv[v]), 64'(e_abv[v]));
          check("av", 64'(my_data_av[v]), 64'(e_av[v]));
        end
        check("ab", 64'(my_data_ab), 64'(e_ab));
        check("z", 64'(my_data_z), 64'(e_z));
        check("out_words", 64'(out_words), 64'(e_words));
      end
    end
  end

  task automatic send(input logic [BUM-1:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_acc) break;
    end
    check("send_timeout", 64'(m_acc), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  logic [AUM-1:0][BUM-1:0] snap_abv0, snap_ab;

  initial begin
    @(negedge clk);
    tick(); tick();
    chk_en = 1'b1;
    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_abv0", 64'(my_data_abv[0]), 64'd0);
    check("rst_av1", 64'(my_data_av[1]), 64'd0);
    check("rst_ab", 64'(my_data_ab), 64'd0);
    check("rst_words", 64'(out_words), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 1: full frame with in_last on the 8th word
    for (int i = 0; i < NW; i++) send(BUM'(8'h10 + i), (i == NW - 1));
    idle();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_abv0", 64'(my_data_abv[0]), 64'h13121110);
    check("t1_abv1", 64'(my_data_abv[1]), 64'h17161514);
    check("t1_ab", 64'(my_data_ab), 64'h04040404);
    check("t1_av0", 64'(my_data_av[0]), 64'hF);
    check("t1_av1", 64'(my_data_av[1]), 64'hF);
    check("t1_z", 64'(my_data_z), 64'd0);
    check("t1_words", 64'(out_words), 64'd8);
    tick();
    check("t1_ready_after", 64'(in_ready), 64'd1);

    // 2: short frame
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b1);
    idle();
    check("t2_abv0", 64'(my_data_abv[0]), 64'h00A3A2A1);
    check("t2_abv1", 64'(my_data_abv[1]), 64'h0);
    check("t2_ab", 64'(my_data_ab), 64'h00A3A2A1);
    check("t2_av0", 64'(my_data_av[0]), 64'h7);
    check("t2_av1", 64'(my_data_av[1]), 64'h0);
    check("t2_z", 64'(my_data_z), 64'd1);
    check("t2_words", 64'(out_words), 64'd3);
    tick();

    // 3: auto-close without in_last; 9th word held off until handoff
    out_ready = 1'b0;
    for (int i = 0; i < NW; i++) send(BUM'(8'h20 + i), 1'b0);
    check("t3_z", 64'(my_data_z), 64'd0);
    check("t3_words", 64'(out_words), 64'd8);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    // 4: backpressure, outputs bit-stable
    snap_abv0 = my_data_abv[0];
    snap_ab   = my_data_ab;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_ready_low", 64'(in_ready), 64'd0);
      check("t4_abv0_stable", 64'(my_data_abv[0]), 64'(snap_abv0));
      check("t4_ab_stable", 64'(my_data_ab), 64'(snap_ab));
    end
    out_ready = 1'b1;
    send(8'h55, 1'b1);
    idle();
    check("t3_next_abv0", 64'(my_data_abv[0]), 64'h00000055);
    check("t3_next_words", 64'(out_words), 64'd1);
    tick();

    // 5: stale clearing
    for (int i = 0; i < NW; i++) send(8'hFF, 1'b0);
    idle();
    tick();
    send(8'h01, 1'b0); send(8'h02, 1'b1);
    idle();
    check("t5_abv0", 64'(my_data_abv[0]), 64'h00000201);
    check("t5_abv1", 64'(my_data_abv[1]), 64'h0);
    check("t5_av0", 64'(my_data_av[0]), 64'h3);
    tick();

    // 6: reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send(BUM'(8'h30 + i), 1'b0);
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(8'h41, 1'b0); send(8'h42, 1'b1);
    idle();
    check("t6_words", 64'(out_words), 64'd2);
    check("t6_abv0", 64'(my_data_abv[0]), 64'h00004241);
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = BUM'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/a_frame_packer.md
Name: a_frame_packer

Overview:
- Upstream feeder for the `a` consumer stage.
- Accepts a serial stream of BUM-bit words over a valid/ready handshake and packs them into a VUM-lane frame of AUM words per lane.
- Presents the frame as packed 2D vectors on the `my_data_*` buses, with its own valid/ready handshake.
- Supports early frame termination (zero padding) and produces per-word valid masks plus an XOR parity lane.

Parameters:
AUM  80  words per lane (outer packed dimension)
BUM  70  bits per word (inner packed dimension)
VUM  1   lanes per frame (unpacked dimension)
CW   $clog2(AUM*VUM+1)  width of word-count output (derived localparam, not overridable)

Ports:
clk          input   1                    clock; all logic on rising edge
rst_n        input   1                    synchronous active-low reset
in_valid     input   1                    input word valid
in_ready     output  1                    block can accept a word
in_data      input   BUM                  input word
in_last      input   1                    word is the last of the frame (early termination allowed)
out_valid    output  1                    frame available
out_ready    input   1                    downstream accepts frame
my_data_abv  output  [AUM-1:0][BUM-1:0] x [VUM]  packed frame, lane v, word a
my_data_ab   output  [AUM-1:0][BUM-1:0]   XOR of all VUM lanes (parity lane)
my_data_av   output  [AUM-1:0] x [VUM]    per-word written mask (1 = real word, 0 = pad)
my_data_z    output  1                    frame was padded (terminated before AUM*VUM words)
out_words    output  CW                   number of real words in frame

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = FILL, word index k = 0.
  - All outputs 0, including in_ready and out_valid.
  - in_ready rises on the first edge after rst_n is sampled high.
  - Reset mid-FILL or mid-HOLD discards the partial or held frame without emitting it.
- State FILL:
  - in_ready = 1.
  - Word accept = in_valid & in_ready.
  - Accepted word k stores into lane v = k / AUM, position a = k % AUM: my_data_abv[v][a] <= in_data, and my_data_av[v][a] <= 1.
  - k increments on each accept.
  - On the first accept of a frame, all abv and av storage not written by that word is cleared to 0, so stale data never leaks between frames.
- FILL -> HOLD: an accept with in_last = 1, or an accept with k = AUM*VUM-1 (frame full), whichever comes first.
  - On that edge: out_words <= k+1, my_data_z <= (k+1 < AUM*VUM), my_data_ab <= XOR over v of the final lane contents, out_valid <= 1.
  - Latency: last word accepted at edge N, out_valid high after edge N (visible in cycle N+1).
- in_last on word AUM*VUM: normal full frame, my_data_z = 0.
- Words beyond a full frame are not accepted, because the state is already HOLD.
- State HOLD:
  - in_ready = 0.
  - All my_data_*, out_words and out_valid are held stable until out_valid & out_ready.
- HOLD -> FILL: on out_valid & out_ready. out_valid <= 0, k <= 0.
  - Frame data outputs keep their last values until overwritten; the consumer must qualify with out_valid.
- No overlap: a new frame is accepted starting the cycle after the handoff. Maximum throughput is one frame per AUM*VUM+1 cycles.
- in_valid while in_ready = 0 is ignored. in_data and in_last are don't-care when in_valid = 0.
- Padded positions hold 0 data with av = 0. Padding participates in the XOR as 0.
- Parameter legality:
  - Elaboration error if AUM < 1, BUM < 1 or VUM < 1.
  - VUM = 1: my_data_ab equals my_data_abv[0].

Test Plan:
1. AUM=4, BUM=8, VUM=2; stream 0x10..0x17, in_last on 0x17, out_ready=1 -> one cycle after the last accept:
   - out_valid=1, abv[0]=0x13121110, abv[1]=0x17161514.
   - ab=0x04040404, av[0]=av[1]=4'hF, z=0, out_words=8.
   - in_ready=1 again the cycle after the handoff.
2. Same config; words 0xA1, 0xA2, 0xA3 with in_last on 0xA3 ->
   - abv[0]=0x00A3A2A1, abv[1]=0, ab=0x00A3A2A1.
   - av[0]=4'b0111, av[1]=4'b0000, z=1, out_words=3.
3. Full frame with no in_last (8 words) -> auto-close after word 8; z=0. A 9th in_valid is held off (in_ready=0) until the handoff, then becomes word 0 of the next frame.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> in_ready=0 and all outputs bit-stable for 5 cycles. Handoff occurs on the first cycle out_ready=1.
5. Stale clearing: frame of 8 words 0xFF, then a frame of 2 words 0x01, 0x02 with in_last -> abv[0]=0x00000201, abv[1]=0, av[0]=4'b0011.
6. Reset: assert rst_n=0 for 1 cycle after 5 words, then send 2 words with in_last -> frame contains only those 2 words; out_words=2; no frame emitted for the aborted 5.
